// File: rtl/issue_scheduler_if.sv
// Request/grant bundle between the reservation station and the issue scheduler:
// per-row readiness, target FU and ROB age in; per-FU grant and completion out.
interface issue_scheduler_if #(
  parameter int ROWS = 16
);
  logic              flush;
  logic [ROWS-1:0]   req_valid;
  logic [2*ROWS-1:0] req_fu;
  logic [6*ROWS-1:0] req_age;
  logic [5:0]        rob_head;
  logic [2:0]        grant_valid;
  logic [11:0]       grant_row;
  logic [2:0]        fu_busy;
  logic [2:0]        done;
  logic [11:0]       done_row;

  modport master (
    output flush, req_valid, req_fu, req_age, rob_head,
    input  grant_valid, grant_row, fu_busy, done, done_row
  );

  modport slave (
    input  flush, req_valid, req_fu, req_age, rob_head,
    output grant_valid, grant_row, fu_busy, done, done_row
  );
endinterface

// File: rtl/issue_scheduler.sv
// Oldest-first issue scheduler: picks one ready row per FU (two ALUs, one memory
// unit), tracks each FU's occupancy and masks rows that are in flight.
module issue_scheduler #(
  parameter int ROWS    = 16,
  parameter int ALU_LAT = 1,
  parameter int MEM_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  issue_scheduler_if.slave ifc
);
  localparam int NFU     = 3;
  localparam int MAX_LAT = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} fu_state_e;

  fu_state_e        state_q [NFU];
  fu_state_e        state_d [NFU];
  logic [CNT_W-1:0] cnt_q   [NFU];
  logic [CNT_W-1:0] cnt_d   [NFU];
  logic [3:0]       row_q   [NFU];
  logic [3:0]       row_d   [NFU];
  logic [3:0]       gr_q    [NFU];
  logic [3:0]       gr_d    [NFU];
  logic [NFU-1:0]   gv_q, gv_d;
  logic [ROWS-1:0]  mask_q, mask_d;

  logic [5:0]       age_dist [ROWS];
  logic [NFU-1:0]   has_cand;
  logic [3:0]       win_row  [NFU];
  logic [5:0]       win_dist [NFU];
  logic [NFU-1:0]   fu_busy, fu_done;
  logic [4*NFU-1:0] grant_row, done_row;

  function automatic logic [CNT_W-1:0] fu_lat(input int f);
    return (f == 2) ? CNT_W'(MEM_LAT) : CNT_W'(ALU_LAT);
  endfunction

  // Distance from the ROB head; 6-bit wrap makes entries just past the head oldest.
  always_comb begin
    for (int i = 0; i < ROWS; i++) age_dist[i] = ifc.req_age[6*i +: 6] - ifc.rob_head;
  end

  // Strict less-than while scanning upward gives ties to the lowest row; FU code 3
  // never matches any f, so those rows are never candidates.
  always_comb begin
    for (int f = 0; f < NFU; f++) begin
      has_cand[f] = 1'b0;
      win_row[f]  = '0;
      win_dist[f] = '0;
    end
    for (int f = 0; f < NFU; f++) begin
      for (int i = 0; i < ROWS; i++) begin
        if (ifc.req_valid[i] && !mask_q[i] && ifc.req_fu[2*i +: 2] == 2'(f) &&
            (!has_cand[f] || age_dist[i] < win_dist[f])) begin
          has_cand[f] = 1'b1;
          win_row[f]  = 4'(i);
          win_dist[f] = age_dist[i];
        end
      end
    end
  end

  always_comb begin
    for (int f = 0; f < NFU; f++) begin
      fu_busy[f]            = (state_q[f] == BUSY);
      fu_done[f]            = (state_q[f] == BUSY) && (cnt_q[f] == CNT_ONE);
      done_row[4*f +: 4]    = fu_done[f] ? row_q[f] : 4'd0;
      grant_row[4*f +: 4]   = gr_q[f];
    end
  end

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    mask_d  = mask_q;
    gv_d    = '0;
    for (int f = 0; f < NFU; f++) gr_d[f] = '0;

    for (int f = 0; f < NFU; f++) begin
      if (fu_done[f]) mask_d[row_q[f]] = 1'b0;
      if (state_q[f] == BUSY) begin
        cnt_d[f] = cnt_q[f] - CNT_ONE;
        if (fu_done[f]) state_d[f] = IDLE;
      end
      // The done cycle doubles as an accept slot so back-to-back ops lose no cycle.
      if ((state_q[f] == IDLE || fu_done[f]) && has_cand[f] && !ifc.flush) begin
        state_d[f]          = BUSY;
        cnt_d[f]            = fu_lat(f);
        row_d[f]            = win_row[f];
        gv_d[f]             = 1'b1;
        gr_d[f]             = win_row[f];
        mask_d[win_row[f]]  = 1'b1;
      end
    end

    if (ifc.flush) begin
      for (int f = 0; f < NFU; f++) begin
        state_d[f] = IDLE;
        cnt_d[f]   = '0;
      end
      mask_d = '0;
      gv_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the per-FU arrays feed outputs directly, so they are reset like any other flop.
      for (int f = 0; f < NFU; f++) begin
        state_q[f] <= IDLE;
        cnt_q[f]   <= '0;
        row_q[f]   <= '0;
        gr_q[f]    <= '0;
      end
      gv_q   <= '0;
      mask_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of every other.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      gr_q    <= gr_d;
      gv_q    <= gv_d;
      mask_q  <= mask_d;
    end
  end

  assign ifc.grant_valid = gv_q;
  assign ifc.grant_row   = grant_row;
  assign ifc.fu_busy     = fu_busy;
  assign ifc.done        = fu_done;
  assign ifc.done_row    = done_row;
endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus a random run scored against
// an interval-based model (each op occupies its FU over absolute cycles [start, start+lat-1]).
module tb_issue_scheduler;
  localparam int ROWS    = 16;
  localparam int ALU_LAT = 1;
  localparam int MEM_LAT = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  issue_scheduler_if #(.ROWS(ROWS)) ifc ();

  issue_scheduler #(.ROWS(ROWS), .ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Model state: one op record per FU, in absolute cycle numbers.
  int m_active [3];
  int m_row    [3];
  int m_start  [3];
  int m_cyc;

  function automatic int fu_latency(input int f);
    return (f == 2) ? MEM_LAT : ALU_LAT;
  endfunction

  task automatic clear_reqs();
    ifc.flush     = 1'b0;
    ifc.req_valid = '0;
    ifc.req_fu    = '0;
    ifc.req_age   = '0;
    ifc.rob_head  = '0;
  endtask

  task automatic set_row(input int i, input int fu, input int age);
    ifc.req_valid[i]       = 1'b1;
    ifc.req_fu[2*i +: 2]   = 2'(fu);
    ifc.req_age[6*i +: 6]  = 6'(age);
  endtask

  task automatic settle(input int n);
    clear_reqs();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_reqs();
    set_row(0, 0, 0);
    set_row(1, 2, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (ifc.grant_valid !== 3'b000 || ifc.grant_row !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_grant: got gv=%b row=%h, want gv=000 row=000", ifc.grant_valid, ifc.grant_row);
    end
    n_checks++;
    if (ifc.fu_busy !== 3'b000 || ifc.done !== 3'b000 || ifc.done_row !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_state: got busy=%b done=%b drow=%h, want all zero", ifc.fu_busy, ifc.done, ifc.done_row);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifc.grant_valid !== 3'b101 || ifc.grant_row !== 12'h100) begin
      n_errors++;
      $display("FAIL first_grant: got gv=%b row=%h, want gv=101 row=100", ifc.grant_valid, ifc.grant_row);
    end
    n_checks++;
    if (ifc.fu_busy !== 3'b101 || ifc.done !== 3'b001) begin
      n_errors++;
      $display("FAIL first_busy: got busy=%b done=%b, want busy=101 done=001", ifc.fu_busy, ifc.done);
    end
    settle(5);
  endtask

  task automatic test_oldest_wrap();
    int exp_row [2] = '{5, 3};
    ifc.rob_head = 6'd62;
    set_row(3, 0, 1);
    set_row(5, 0, 63);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (ifc.grant_valid[0] !== 1'b1 || int'(ifc.grant_row[3:0]) != exp_row[c] ||
          ifc.done[0] !== 1'b1 || int'(ifc.done_row[3:0]) != exp_row[c]) begin
        n_errors++;
        $display("FAIL wrap_cycle%0d: got gv=%b row=%0d done=%b drow=%0d, want row %0d granted and done",
                 c, ifc.grant_valid[0], ifc.grant_row[3:0], ifc.done[0], ifc.done_row[3:0], exp_row[c]);
      end
    end
    settle(3);
  endtask

  task automatic test_tie();
    int exp_row [2] = '{2, 7};
    ifc.rob_head = 6'd0;
    set_row(2, 1, 10);
    set_row(7, 1, 10);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (ifc.grant_valid[1] !== 1'b1 || int'(ifc.grant_row[7:4]) != exp_row[c] ||
          ifc.done[1] !== 1'b1 || int'(ifc.done_row[7:4]) != exp_row[c]) begin
        n_errors++;
        $display("FAIL tie_cycle%0d: got gv=%b row=%0d done=%b drow=%0d, want row %0d granted and done",
                 c, ifc.grant_valid[1], ifc.grant_row[7:4], ifc.done[1], ifc.done_row[7:4], exp_row[c]);
      end
    end
    settle(3);
  endtask

  task automatic test_mem_latency();
    logic exp_gv   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int   exp_grow [6] = '{4, 0, 0, 9, 0, 0};
    logic exp_done [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   exp_drow [6] = '{0, 0, 4, 0, 0, 9};
    ifc.rob_head = 6'd0;
    set_row(4, 2, 5);
    set_row(9, 2, 5);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (ifc.grant_valid[2] !== exp_gv[c] || int'(ifc.grant_row[11:8]) != exp_grow[c] ||
          ifc.done[2] !== exp_done[c] || int'(ifc.done_row[11:8]) != exp_drow[c] ||
          ifc.fu_busy[2] !== 1'b1) begin
        n_errors++;
        $display("FAIL mem_t+%0d: got gv=%b row=%0d done=%b drow=%0d busy=%b, want gv=%b row=%0d done=%b drow=%0d busy=1",
                 c, ifc.grant_valid[2], ifc.grant_row[11:8], ifc.done[2], ifc.done_row[11:8], ifc.fu_busy[2],
                 exp_gv[c], exp_grow[c], exp_done[c], exp_drow[c]);
      end
    end
    settle(4);
  endtask

  task automatic test_flush();
    ifc.rob_head = 6'd0;
    set_row(4, 2, 0);
    @(negedge clk);
    n_checks++;
    if (ifc.grant_valid !== 3'b100) begin
      n_errors++;
      $display("FAIL flush_grant: got gv=%b, want 100", ifc.grant_valid);
    end
    @(negedge clk);
    n_checks++;
    if (ifc.fu_busy[2] !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_prebusy: got busy2=%b, want 1", ifc.fu_busy[2]);
    end
    ifc.flush = 1'b1;
    set_row(1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (ifc.fu_busy !== 3'b000 || ifc.done !== 3'b000 || ifc.grant_valid !== 3'b000) begin
      n_errors++;
      $display("FAIL flush_kill: got busy=%b done=%b gv=%b, want all zero", ifc.fu_busy, ifc.done, ifc.grant_valid);
    end
    ifc.flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifc.grant_valid !== 3'b101 || ifc.grant_row !== 12'h401) begin
      n_errors++;
      $display("FAIL flush_mask: got gv=%b row=%h, want gv=101 row=401", ifc.grant_valid, ifc.grant_row);
    end
    settle(5);
  endtask

  task automatic test_reset_mid_op();
    ifc.rob_head = 6'd0;
    set_row(4, 2, 0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ifc.fu_busy[2] !== 1'b1 || ifc.done[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL midop_busy: got busy2=%b done2=%b, want busy2=1 done2=0", ifc.fu_busy[2], ifc.done[2]);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (ifc.grant_valid !== 3'b000 || ifc.grant_row !== 12'h000 || ifc.fu_busy !== 3'b000 ||
        ifc.done !== 3'b000 || ifc.done_row !== 12'h000) begin
      n_errors++;
      $display("FAIL async_reset: got gv=%b row=%h busy=%b done=%b drow=%h, want all zero",
               ifc.grant_valid, ifc.grant_row, ifc.fu_busy, ifc.done, ifc.done_row);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifc.grant_valid !== 3'b100 || ifc.grant_row !== 12'h400) begin
      n_errors++;
      $display("FAIL post_reset_grant: got gv=%b row=%h, want gv=100 row=400", ifc.grant_valid, ifc.grant_row);
    end
    settle(5);
  endtask

  task automatic test_invalid_fu();
    set_row(0, 3, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (ifc.grant_valid !== 3'b000 || ifc.fu_busy !== 3'b000) begin
        n_errors++;
        $display("FAIL invalid_fu_c%0d: got gv=%b busy=%b, want 000/000", c, ifc.grant_valid, ifc.fu_busy);
      end
    end
    settle(2);
  endtask

  // Advance the model from the current cycle to the next using the inputs now applied.
  task automatic model_step();
    bit in_flight [ROWS];
    for (int i = 0; i < ROWS; i++) in_flight[i] = 1'b0;
    for (int f = 0; f < 3; f++) if (m_active[f] != 0) in_flight[m_row[f]] = 1'b1;
    if (ifc.flush) begin
      for (int f = 0; f < 3; f++) m_active[f] = 0;
    end else begin
      for (int f = 0; f < 3; f++) begin
        bit ends_now = (m_active[f] != 0) && (m_start[f] + fu_latency(f) - 1 == m_cyc);
        int best   = -1;
        int best_d = 64;
        if (m_active[f] == 0 || ends_now) begin
          for (int i = 0; i < ROWS; i++) begin
            int d;
            d = (int'(ifc.req_age[6*i +: 6]) - int'(ifc.rob_head)) & 63;
            if (ifc.req_valid[i] && !in_flight[i] && int'(ifc.req_fu[2*i +: 2]) == f && d < best_d) begin
              best   = i;
              best_d = d;
            end
          end
        end
        if (best >= 0) begin
          m_active[f] = 1;
          m_row[f]    = best;
          m_start[f]  = m_cyc + 1;
        end else if (ends_now) begin
          m_active[f] = 0;
        end
      end
    end
    m_cyc++;
  endtask

  task automatic test_random();
    logic [2:0]  e_gv, e_busy, e_done;
    logic [11:0] e_grow, e_drow;
    reset = 1'b1;
    clear_reqs();
    @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 3; f++) begin
      m_active[f] = 0;
      m_row[f]    = 0;
      m_start[f]  = 0;
    end
    m_cyc = 0;
    for (int n = 0; n < 600; n++) begin
      e_gv = '0; e_busy = '0; e_done = '0; e_grow = '0; e_drow = '0;
      for (int f = 0; f < 3; f++) begin
        if (m_active[f] != 0) begin
          e_busy[f] = 1'b1;
          if (m_start[f] == m_cyc) begin
            e_gv[f]          = 1'b1;
            e_grow[4*f +: 4] = 4'(m_row[f]);
          end
          if (m_start[f] + fu_latency(f) - 1 == m_cyc) begin
            e_done[f]        = 1'b1;
            e_drow[4*f +: 4] = 4'(m_row[f]);
          end
        end
      end
      n_checks++;
      if (ifc.grant_valid !== e_gv || ifc.grant_row !== e_grow) begin
        n_errors++;
        $display("FAIL rand_grant cyc%0d: got gv=%b row=%h, want gv=%b row=%h", n, ifc.grant_valid, ifc.grant_row, e_gv, e_grow);
      end
      n_checks++;
      if (ifc.fu_busy !== e_busy) begin
        n_errors++;
        $display("FAIL rand_busy cyc%0d: got %b, want %b", n, ifc.fu_busy, e_busy);
      end
      n_checks++;
      if (ifc.done !== e_done || ifc.done_row !== e_drow) begin
        n_errors++;
        $display("FAIL rand_done cyc%0d: got done=%b drow=%h, want done=%b drow=%h", n, ifc.done, ifc.done_row, e_done, e_drow);
      end
      for (int i = 0; i < ROWS; i++) begin
        ifc.req_valid[i]      = 1'($urandom_range(0, 1));
        ifc.req_fu[2*i +: 2]  = 2'($urandom_range(0, 3));
        ifc.req_age[6*i +: 6] = 6'($urandom_range(0, 63));
      end
      ifc.rob_head = 6'($urandom_range(0, 63));
      ifc.flush    = ($urandom_range(0, 24) == 0);
      model_step();
      @(negedge clk);
    end
    settle(4);
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_oldest_wrap();
    test_tie();
    test_mem_latency();
    test_flush();
    test_reset_mid_op();
    test_invalid_fu();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter ROWS, default 16: number of reservation-station rows arbitrated.
REQ-002 SHALL have parameter ALU_LAT, default 1: cycles an ALU FU (0, 1) stays busy per issued op.
REQ-003 SHALL have parameter MEM_LAT, default 3: cycles the memory FU (2) stays busy per issued op.
REQ-004 SHALL have ports, one per line:
  clk  in  1  single clock, rising edge;
  reset  in  1  asynchronous, active-high;
  flush  in  1  synchronous kill of all in-flight ops;
  req_valid  in  ROWS  row i operands ready and waiting;
  req_fu  in  2*ROWS  row i target FU in bits [2i+1:2i]; value 3 is invalid;
  req_age  in  6*ROWS  row i ROB index in bits [6i+5:6i];
  rob_head  in  6  ROB index of oldest unretired entry;
  grant_valid  out  3  FU f issued a row this cycle;
  grant_row  out  3*4  row issued to FU f in bits [4f+3:4f];
  fu_busy  out  3  FU f occupied;
  done  out  3  FU f finishes its op this cycle;
  done_row  out  3*4  row finishing on FU f.

Function
REQ-005 SHALL compute each row's age distance as (req_age - rob_head) mod 64, 6-bit wrap-around subtraction.
REQ-006 SHALL treat row i as a candidate for FU f only if req_valid[i]=1, req_fu field = f, and row i is not masked.
REQ-007 SHALL select, per FU, the candidate with the smallest age distance; ties SHALL go to the lowest row index.
REQ-008 SHALL ignore rows with req_fu=3; such rows never produce a grant.
REQ-009 SHALL keep per FU a two-state machine, IDLE and BUSY, plus a down-counter cnt.
REQ-010 SHALL accept a grant at a clock edge for FU f when f is IDLE, or when f is BUSY with cnt=1, and a candidate exists.
REQ-011 On accept, SHALL register grant_valid[f]=1 and grant_row[f]=winner, set cnt to the FU latency, and enter BUSY; all are visible the cycle after the edge.
REQ-012 grant_valid SHALL be a one-cycle pulse; grant_row SHALL read 0 whenever grant_valid[f]=0.
REQ-013 In BUSY, cnt SHALL decrement each cycle; done[f] SHALL be 1 exactly in the cycle cnt=1, with done_row[f] equal to the granted row.
REQ-014 With ALU_LAT=1, grant_valid and done SHALL assert in the same cycle, giving one op per cycle per ALU.
REQ-015 With MEM_LAT=3, a grant visible at cycle t SHALL give done at t+2; the next MEM grant SHALL be visible no earlier than t+3.
REQ-016 fu_busy[f] SHALL be 1 exactly while the FU is in BUSY, including the grant and done cycles.
REQ-017 SHALL set mask bit i at the edge that grants row i, and clear it at the edge that ends row i's done cycle; a masked row SHALL NOT be granted even if req_valid stays high.
REQ-018 The same row SHALL NOT be granted to two FUs, which follows from the single req_fu field.
REQ-019 Flush SHALL, at the next edge, clear all FU state to IDLE, cnt to 0, and the mask to 0, and drive grant_valid=0 and done=0; killed ops SHALL NOT produce done.
REQ-020 A grant SHALL NOT be accepted on the edge where flush=1.
REQ-021 The three FUs SHALL arbitrate independently in the same cycle.

Reset
REQ-022 reset=1 SHALL immediately force grant_valid=0, grant_row=0, fu_busy=0, done=0, done_row=0, all FUs IDLE, cnt=0, mask=0.
REQ-023 reset SHALL dominate flush and any pending grant; the first grant SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-024 Oldest-first with wrap: rob_head=62; rows 3 (age 1) and 5 (age 63), both on FU0 -> grant_row[0]=5, then row 3 in the next cycle.
REQ-025 Tie: rows 2 and 7, both FU1, both age 10, rob_head=0 -> row 2 first, row 7 one cycle later; done pulses in the same cycles as their grants.
REQ-026 MEM latency: rows 4 and 9 on FU2, held valid -> row 4 granted at t, done at t+2 with done_row=4; row 9 granted at t+3; row 4 never re-granted.
REQ-027 Flush mid-op: MEM grant at t, flush=1 during t+1 -> at t+2 fu_busy[2]=0, no done at t+2, mask empty.
REQ-028 Reset mid-op: assert reset asynchronously while FU2 cnt=2 -> all outputs 0 without waiting for a clock edge; after release, a pending row is granted on the first edge.
REQ-029 Invalid FU: row 0 with req_fu=3, valid, and no other requests -> no grant for 20 cycles.
